// File: rtl/scroll_menu_if.sv
// Key/back inputs, chart store read port and display outputs of the scroll menu.
interface scroll_menu_if #(
    parameter int VIS_ROWS = 5,
    parameter int NAME_LEN = 16
);
    logic                      key_up;
    logic                      key_down;
    logic                      key_left;
    logic                      key_right;
    logic                      back;
    logic [8*NAME_LEN-1:0]     chart_name;
    logic [7:0]                read_chart_id;
    logic [VIS_ROWS*32*8-1:0]  row_text;
    logic [63:0]               seg;
    logic [1:0]                state;
    logic                      auto_play;
    logic                      busy;
    logic [7:0]                cursor;

    modport master (
        output key_up, key_down, key_left, key_right, back, chart_name,
        input  read_chart_id, row_text, seg, state, auto_play, busy, cursor
    );

    modport slave (
        input  key_up, key_down, key_left, key_right, back, chart_name,
        output read_chart_id, row_text, seg, state, auto_play, busy, cursor
    );
endinterface

// File: rtl/scroll_menu.sv
// Scrolling chart-select menu: cursor/window navigation plus a row-name cache refilled from the chart store.
//   state  | meaning
//   IDLE   | cache valid, read_chart_id shows the selected chart
//   FETCH  | present id of row's chart (non-chart rows skip in one cycle)
//   WAIT   | count down READ_LAT cycles for chart_name
//   STORE  | capture chart_name into the row cache
module scroll_menu #(
    parameter int NUM_CHARTS = 16,
    parameter int VIS_ROWS   = 5,
    parameter int NAME_LEN   = 16,
    parameter int READ_LAT   = 1
) (
    input logic          prog_clk,
    input logic          rst,
    scroll_menu_if.slave bus
);
    localparam int ITEMS = NUM_CHARTS + 2;
    localparam int RW    = $clog2(VIS_ROWS);
    localparam logic [8*13-1:0] HIST_NAME = "Score History";
    localparam logic [8*9-1:0]  FREE_NAME = "Free play";

    typedef enum logic [1:0] {MENU = 2'd0, HISTORY = 2'd1, PLAY = 2'd2} ui_state_t;
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, STORE} fill_state_t;

    ui_state_t             ui_state, ui_state_n;
    fill_state_t           fill_state, fill_state_n;
    logic [7:0]            cursor, cursor_n, top, top_n;
    logic                  auto_play, auto_play_n;
    logic [63:0]           seg, seg_n;
    logic [RW-1:0]         row, row_n;
    logic [7:0]            wait_cnt, wait_cnt_n;
    logic                  store_en, refill_req, busy, one_key, last_row;
    logic [7:0]            fetch_item;
    logic [3:0]            keys;
    logic [8*NAME_LEN-1:0] name_cache [VIS_ROWS];

    function automatic logic [15:0] dec2(input logic [7:0] v);
        return {8'd48 + v / 8'd10, 8'd48 + v % 8'd10};
    endfunction

    function automatic logic is_chart(input logic [7:0] item);
        return (item >= 8'd2) && (item < 8'(ITEMS));
    endfunction

    function automatic logic [63:0] seg_text(input logic [7:0] item);
        if (item == 8'd0) return "history ";
        if (item == 8'd1) return "free    ";
        return {"song  ", dec2(item - 8'd1)};
    endfunction

    // Char c of a row sits at bits [255-8c -: 8].
    function automatic logic [255:0] render_row(input logic [7:0] item, input logic [7:0] cur,
                                                input logic [8*NAME_LEN-1:0] name);
        logic [255:0] t;
        t = {32{8'h20}};
        if (item < 8'(ITEMS)) begin
            if (item == cur) t[255 -: 24] = ">>>";
            t[223 -: 8] = "[";
            if (item != 8'd0) t[215 -: 16] = dec2((item == 8'd1) ? 8'd0 : item - 8'd1);
            t[199 -: 8] = "]";
            if (item == 8'd0)      t[183 -: 104] = HIST_NAME;
            else if (item == 8'd1) t[183 -: 72] = FREE_NAME;
            else                   t[183 -: 8*NAME_LEN] = name;
        end
        return t;
    endfunction

    assign keys    = {bus.key_up, bus.key_down, bus.key_left, bus.key_right};
    assign one_key = (keys != 4'd0) && ((keys & (keys - 4'd1)) == 4'd0);
    assign busy    = (fill_state != IDLE);

    always_comb begin
        cursor_n    = cursor;
        top_n       = top;
        ui_state_n  = ui_state;
        auto_play_n = auto_play;
        seg_n       = seg;
        if (ui_state == MENU) begin
            if (!busy && one_key) begin
                if (bus.key_up || bus.key_down) begin
                    if (bus.key_up) cursor_n = (cursor == 8'd0) ? 8'(ITEMS - 1) : cursor - 8'd1;
                    else            cursor_n = (cursor == 8'(ITEMS - 1)) ? 8'd0 : cursor + 8'd1;
                    seg_n = seg_text(cursor_n);
                    if (cursor_n < top)                          top_n = cursor_n;
                    else if (cursor_n > top + 8'(VIS_ROWS - 1)) top_n = cursor_n - 8'(VIS_ROWS - 1);
                end else if (bus.key_right) begin
                    if (cursor == 8'd0) ui_state_n = HISTORY;
                    else begin
                        ui_state_n  = PLAY;
                        auto_play_n = 1'b0;
                    end
                end else if (cursor != 8'd0) begin
                    ui_state_n  = PLAY;
                    auto_play_n = 1'b1;
                end
            end
        end else if (bus.back) begin
            ui_state_n = MENU;
        end
    end

    assign refill_req = (top_n != top);
    assign fetch_item = top + 8'(row);
    assign last_row   = (row == RW'(VIS_ROWS - 1));

    always_comb begin
        fill_state_n = fill_state;
        row_n        = row;
        wait_cnt_n   = wait_cnt;
        store_en     = 1'b0;
        case (fill_state)
            FETCH: begin
                if (is_chart(fetch_item)) begin
                    fill_state_n = WAIT;
                    wait_cnt_n   = 8'(READ_LAT - 1);
                end else begin
                    fill_state_n = last_row ? IDLE : FETCH;
                    row_n        = last_row ? '0 : row + RW'(1);
                end
            end
            WAIT: begin
                if (wait_cnt == 8'd0) fill_state_n = STORE;
                else                  wait_cnt_n   = wait_cnt - 8'd1;
            end
            STORE: begin
                store_en     = 1'b1;
                fill_state_n = last_row ? IDLE : FETCH;
                row_n        = last_row ? '0 : row + RW'(1);
            end
            default: ;
        endcase
        // A window move always restarts the fill from the first visible row.
        if (refill_req) begin
            fill_state_n = FETCH;
            row_n        = '0;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (rst) begin
            ui_state   <= MENU;
            cursor     <= 8'd0;
            top        <= 8'd0;
            auto_play  <= 1'b0;
            seg        <= "        ";
            fill_state <= FETCH;
            row        <= '0;
            wait_cnt   <= 8'd0;
        end else begin
            ui_state   <= ui_state_n;
            cursor     <= cursor_n;
            top        <= top_n;
            auto_play  <= auto_play_n;
            seg        <= seg_n;
            fill_state <= fill_state_n;
            row        <= row_n;
            wait_cnt   <= wait_cnt_n;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (rst) begin
            for (int r = 0; r < VIS_ROWS; r++) name_cache[r] <= {NAME_LEN{8'h20}};
        end else if (store_en) begin
            name_cache[row] <= bus.chart_name;
        end
    end

    always_comb begin
        if (fill_state == IDLE) bus.read_chart_id = (cursor >= 8'd2) ? cursor - 8'd1 : 8'd0;
        else bus.read_chart_id = is_chart(fetch_item) ? fetch_item - 8'd1 : 8'd0;
    end

    always_comb begin
        bus.row_text = '0;
        for (int r = 0; r < VIS_ROWS; r++)
            bus.row_text[(VIS_ROWS - r)*256 - 1 -: 256] = render_row(top + 8'(r), cursor, name_cache[r]);
    end

    assign bus.seg       = seg;
    assign bus.state     = ui_state;
    assign bus.auto_play = auto_play;
    assign bus.busy      = busy;
    assign bus.cursor    = cursor;
endmodule

// File: tb/tb_scroll_menu.sv
// Directed bench for scroll_menu: READ_LAT=1 instance for navigation, READ_LAT=3 instance for mid-refill reset.
module tb_scroll_menu;
    logic prog_clk, rst, rst3;
    int   checks, errors;

    scroll_menu_if #(.VIS_ROWS(5), .NAME_LEN(16)) bus1 ();
    scroll_menu_if #(.VIS_ROWS(5), .NAME_LEN(16)) bus3 ();

    scroll_menu #(.NUM_CHARTS(16), .VIS_ROWS(5), .NAME_LEN(16), .READ_LAT(1)) dut (
        .prog_clk(prog_clk), .rst(rst), .bus(bus1.slave));
    scroll_menu #(.NUM_CHARTS(16), .VIS_ROWS(5), .NAME_LEN(16), .READ_LAT(3)) dut3 (
        .prog_clk(prog_clk), .rst(rst3), .bus(bus3.slave));

    localparam logic [255:0] ROW_HIST_PTR = {">>> [  ] Score History", {10{8'h20}}};
    localparam logic [255:0] ROW_FREE     = {"    [00] Free play", {14{8'h20}}};
    localparam logic [255:0] ROW_C01      = {"    [01] ", "Chart 01        ", {7{8'h20}}};
    localparam logic [255:0] ROW_C01_RST  = {"    [01] ", {23{8'h20}}};
    localparam logic [255:0] ROW_C12      = {"    [12] ", "Chart 12        ", {7{8'h20}}};
    localparam logic [255:0] ROW_C16_PTR  = {">>> [16] ", "Chart 16        ", {7{8'h20}}};
    localparam logic [255:0] ROW_C04_PTR  = {">>> [04] ", "Chart 04        ", {7{8'h20}}};

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Chart store model: name "Chart NN" padded, delivered READ_LAT cycles after the id.
    function automatic logic [127:0] chart_of(input logic [7:0] id);
        logic [15:0] d;
        d = {8'd48 + id / 8'd10, 8'd48 + id % 8'd10};
        return {"Chart ", d, "        "};
    endfunction

    logic [127:0] pipe1;
    logic [127:0] pipe3 [3];
    always @(posedge prog_clk) begin
        pipe1    <= chart_of(bus1.read_chart_id);
        pipe3[0] <= chart_of(bus3.read_chart_id);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign bus1.chart_name = pipe1;
    assign bus3.chart_name = pipe3[2];

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // k = {up, down, left, right}
    task automatic press(input logic [3:0] k, input logic b);
        {bus1.key_up, bus1.key_down, bus1.key_left, bus1.key_right} = k;
        bus1.back = b;
        tick();
        {bus1.key_up, bus1.key_down, bus1.key_left, bus1.key_right} = 4'd0;
        bus1.back = 1'b0;
    endtask

    task automatic wait_idle1(input int limit, output int n);
        n = 0;
        while (bus1.busy === 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus1.cursor !== 8'd0) begin errors++; $display("FAIL rst_cursor: got %0d want 0", bus1.cursor); end
        checks++; if (bus1.state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", bus1.state); end
        checks++; if (bus1.auto_play !== 1'b0) begin errors++; $display("FAIL rst_auto: got %b want 0", bus1.auto_play); end
        checks++; if (bus1.seg !== "        ") begin errors++; $display("FAIL rst_seg: got '%s' want spaces", bus1.seg); end
        checks++; if (bus1.read_chart_id !== 8'd0) begin errors++; $display("FAIL rst_read_id: got %0d want 0", bus1.read_chart_id); end
        checks++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", bus1.busy); end
        checks++; if (bus1.row_text[767:512] !== ROW_C01_RST) begin errors++; $display("FAIL rst_row2: got '%s' want '%s'", bus1.row_text[767:512], ROW_C01_RST); end
        rst = 1'b0;
        wait_idle1(40, n);
        checks++; if (bus1.busy !== 1'b0 || n > 16) begin errors++; $display("FAIL init_refill_time: got %0d cycles busy=%b want <=16 busy=0", n, bus1.busy); end
        checks++; if (bus1.row_text[767:512] !== ROW_C01) begin errors++; $display("FAIL init_row2: got '%s' want '%s'", bus1.row_text[767:512], ROW_C01); end
        checks++; if (bus1.row_text[1279:1024] !== ROW_HIST_PTR) begin errors++; $display("FAIL init_row0: got '%s' want '%s'", bus1.row_text[1279:1024], ROW_HIST_PTR); end
        checks++; if (bus1.row_text[1023:768] !== ROW_FREE) begin errors++; $display("FAIL init_row1: got '%s' want '%s'", bus1.row_text[1023:768], ROW_FREE); end
    endtask

    task automatic test_menu_keys();
        press(4'b0010, 1'b0);
        checks++; if (bus1.state !== 2'd0) begin errors++; $display("FAIL left_item0_state: got %0d want 0", bus1.state); end
        press(4'b1100, 1'b0);
        checks++; if (bus1.cursor !== 8'd0 || bus1.busy !== 1'b0) begin errors++; $display("FAIL updown_same: got cursor %0d busy %b want 0 0", bus1.cursor, bus1.busy); end
        press(4'b0001, 1'b0);
        checks++; if (bus1.state !== 2'd1 || bus1.auto_play !== 1'b0) begin errors++; $display("FAIL right_item0: got state %0d auto %b want 1 0", bus1.state, bus1.auto_play); end
        press(4'b0100, 1'b0);
        checks++; if (bus1.cursor !== 8'd0 || bus1.state !== 2'd1) begin errors++; $display("FAIL key_in_history: got cursor %0d state %0d want 0 1", bus1.cursor, bus1.state); end
        press(4'b0000, 1'b1);
        checks++; if (bus1.state !== 2'd0) begin errors++; $display("FAIL back_history: got %0d want 0", bus1.state); end
    endtask

    task automatic test_wrap();
        int n;
        press(4'b1000, 1'b0);
        checks++; if (bus1.cursor !== 8'd17) begin errors++; $display("FAIL wrap_cursor: got %0d want 17", bus1.cursor); end
        checks++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL wrap_busy: got %b want 1", bus1.busy); end
        checks++; if (bus1.seg !== "song  16") begin errors++; $display("FAIL wrap_seg: got '%s' want 'song  16'", bus1.seg); end
        checks++; if (bus1.read_chart_id !== 8'd12) begin errors++; $display("FAIL wrap_fetch_id: got %0d want 12", bus1.read_chart_id); end
        wait_idle1(40, n);
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL wrap_refill_timeout: got busy %b after %0d cycles want 0", bus1.busy, n); end
        checks++; if (bus1.row_text[255:0] !== ROW_C16_PTR) begin errors++; $display("FAIL wrap_row4: got '%s' want '%s'", bus1.row_text[255:0], ROW_C16_PTR); end
        checks++; if (bus1.row_text[1279:1024] !== ROW_C12) begin errors++; $display("FAIL wrap_row0: got '%s' want '%s'", bus1.row_text[1279:1024], ROW_C12); end
        checks++; if (bus1.read_chart_id !== 8'd16) begin errors++; $display("FAIL wrap_sel_id: got %0d want 16", bus1.read_chart_id); end
        press(4'b0100, 1'b0);
        checks++; if (bus1.cursor !== 8'd0 || bus1.busy !== 1'b1) begin errors++; $display("FAIL wrap_down: got cursor %0d busy %b want 0 1", bus1.cursor, bus1.busy); end
        checks++; if (bus1.seg !== "history ") begin errors++; $display("FAIL wrap_down_seg: got '%s' want 'history '", bus1.seg); end
        wait_idle1(40, n);
        checks++; if (bus1.row_text[1279:1024] !== ROW_HIST_PTR) begin errors++; $display("FAIL wrap_back_row0: got '%s' want '%s'", bus1.row_text[1279:1024], ROW_HIST_PTR); end
    endtask

    task automatic test_scroll();
        int n;
        for (int i = 0; i < 4; i++) press(4'b0100, 1'b0);
        checks++; if (bus1.cursor !== 8'd4 || bus1.busy !== 1'b0) begin errors++; $display("FAIL scroll4: got cursor %0d busy %b want 4 0", bus1.cursor, bus1.busy); end
        checks++; if (bus1.seg !== "song  03") begin errors++; $display("FAIL scroll4_seg: got '%s' want 'song  03'", bus1.seg); end
        press(4'b0100, 1'b0);
        checks++; if (bus1.cursor !== 8'd5 || bus1.busy !== 1'b1) begin errors++; $display("FAIL scroll5: got cursor %0d busy %b want 5 1", bus1.cursor, bus1.busy); end
        checks++; if (bus1.seg !== "song  04") begin errors++; $display("FAIL scroll5_seg: got '%s' want 'song  04'", bus1.seg); end
        press(4'b0100, 1'b0);
        checks++; if (bus1.cursor !== 8'd5) begin errors++; $display("FAIL key_while_busy: got %0d want 5", bus1.cursor); end
        wait_idle1(40, n);
        checks++; if (bus1.row_text[1279:1024] !== ROW_FREE) begin errors++; $display("FAIL scroll_row0: got '%s' want '%s'", bus1.row_text[1279:1024], ROW_FREE); end
        checks++; if (bus1.row_text[255:0] !== ROW_C04_PTR) begin errors++; $display("FAIL scroll_row4: got '%s' want '%s'", bus1.row_text[255:0], ROW_C04_PTR); end
    endtask

    task automatic test_play();
        press(4'b1000, 1'b0);
        press(4'b1000, 1'b0);
        checks++; if (bus1.cursor !== 8'd3 || bus1.busy !== 1'b0) begin errors++; $display("FAIL play_cursor3: got cursor %0d busy %b want 3 0", bus1.cursor, bus1.busy); end
        checks++; if (bus1.read_chart_id !== 8'd2) begin errors++; $display("FAIL play_sel_id: got %0d want 2", bus1.read_chart_id); end
        press(4'b0010, 1'b0);
        checks++; if (bus1.state !== 2'd2 || bus1.auto_play !== 1'b1) begin errors++; $display("FAIL left_play: got state %0d auto %b want 2 1", bus1.state, bus1.auto_play); end
        press(4'b0100, 1'b0);
        checks++; if (bus1.cursor !== 8'd3 || bus1.state !== 2'd2) begin errors++; $display("FAIL key_in_play: got cursor %0d state %0d want 3 2", bus1.cursor, bus1.state); end
        press(4'b0000, 1'b1);
        checks++; if (bus1.state !== 2'd0 || bus1.cursor !== 8'd3 || bus1.auto_play !== 1'b1) begin errors++; $display("FAIL back_play: got state %0d cursor %0d auto %b want 0 3 1", bus1.state, bus1.cursor, bus1.auto_play); end
        press(4'b0001, 1'b0);
        checks++; if (bus1.state !== 2'd2 || bus1.auto_play !== 1'b0) begin errors++; $display("FAIL right_play: got state %0d auto %b want 2 0", bus1.state, bus1.auto_play); end
        rst = 1'b1;
        tick();
        checks++; if (bus1.state !== 2'd0 || bus1.cursor !== 8'd0 || bus1.auto_play !== 1'b0 || bus1.busy !== 1'b1) begin
            errors++; $display("FAIL rst_in_play: got state %0d cursor %0d auto %b busy %b want 0 0 0 1", bus1.state, bus1.cursor, bus1.auto_play, bus1.busy); end
        rst = 1'b0;
    endtask

    task automatic test_reset_midrefill();
        int n;
        rst3 = 1'b0;
        n = 0;
        while (bus3.busy === 1'b1 && n < 60) begin tick(); n++; end
        checks++; if (bus3.busy !== 1'b0 || n > 26) begin errors++; $display("FAIL lat3_refill_time: got %0d cycles busy=%b want <=26 busy=0", n, bus3.busy); end
        checks++; if (bus3.row_text[767:512] !== ROW_C01) begin errors++; $display("FAIL lat3_row2: got '%s' want '%s'", bus3.row_text[767:512], ROW_C01); end
        for (int i = 0; i < 5; i++) begin
            bus3.key_down = 1'b1;
            tick();
            bus3.key_down = 1'b0;
        end
        checks++; if (bus3.cursor !== 8'd5 || bus3.busy !== 1'b1) begin errors++; $display("FAIL lat3_scroll: got cursor %0d busy %b want 5 1", bus3.cursor, bus3.busy); end
        tick();
        tick();
        rst3 = 1'b1;
        tick();
        checks++; if (bus3.cursor !== 8'd0 || bus3.state !== 2'd0 || bus3.auto_play !== 1'b0 || bus3.busy !== 1'b1 || bus3.read_chart_id !== 8'd0) begin
            errors++; $display("FAIL lat3_rst_regs: got cursor %0d state %0d auto %b busy %b id %0d want 0 0 0 1 0", bus3.cursor, bus3.state, bus3.auto_play, bus3.busy, bus3.read_chart_id); end
        checks++; if (bus3.seg !== "        ") begin errors++; $display("FAIL lat3_rst_seg: got '%s' want spaces", bus3.seg); end
        checks++; if (bus3.row_text[767:512] !== ROW_C01_RST) begin errors++; $display("FAIL lat3_rst_cache: got '%s' want '%s'", bus3.row_text[767:512], ROW_C01_RST); end
        rst3 = 1'b0;
        n = 0;
        while (bus3.busy === 1'b1 && n < 60) begin tick(); n++; end
        checks++; if (bus3.busy !== 1'b0 || n > 26) begin errors++; $display("FAIL lat3_rerefill_time: got %0d cycles busy=%b want <=26 busy=0", n, bus3.busy); end
        checks++; if (bus3.row_text[767:512] !== ROW_C01) begin errors++; $display("FAIL lat3_rerefill_row2: got '%s' want '%s'", bus3.row_text[767:512], ROW_C01); end
        checks++; if (bus3.row_text[1279:1024] !== ROW_HIST_PTR) begin errors++; $display("FAIL lat3_rerefill_row0: got '%s' want '%s'", bus3.row_text[1279:1024], ROW_HIST_PTR); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        rst3   = 1'b1;
        {bus1.key_up, bus1.key_down, bus1.key_left, bus1.key_right, bus1.back} = 5'd0;
        {bus3.key_up, bus3.key_down, bus3.key_left, bus3.key_right, bus3.back} = 5'd0;
        test_reset();
        test_menu_keys();
        test_wrap();
        test_scroll();
        test_play();
        test_reset_midrefill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
